// File: rtl/ray_point_v.sv
// Ray point reconstruction P = O + t*D in signed 16.16, with one multiplier shared across x, y and z.
// Latency: result valid 3 cycles after accept. At most one transaction every 5 cycles.
// Backpressure: the result is held in DONE until out_ready. in_ready is high only in IDLE.
module ray_point_v #(
    parameter int FRAC     = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ox,
    input  logic [31:0] oy,
    input  logic [31:0] oz,
    input  logic [31:0] dx,
    input  logic [31:0] dy,
    input  logic [31:0] dz,
    input  logic [31:0] t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] px,
    output logic [31:0] py,
    output logic [31:0] pz,
    output logic        ovf
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MX   = 3'd1,
        MY   = 3'd2,
        MZ   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;

    logic [31:0] ox_r, oy_r, oz_r;
    logic [31:0] dx_r, dy_r, dz_r;
    logic [31:0] t_r;

    logic [31:0]        sel_o;
    logic [31:0]        sel_d;
    logic signed [63:0] d_ext;
    logic signed [63:0] t_ext;
    logic signed [63:0] o_ext;
    logic signed [63:0] prod;
    logic signed [63:0] scaled;
    logic signed [63:0] sum;
    logic               c_ovf;
    logic [31:0]        c_res;

    assign in_ready = (state == IDLE);

    // The component handled this cycle is chosen by the state. It feeds the single multiplier.
    always_comb begin
        sel_o = ox_r;
        sel_d = dx_r;
        case (state)
            MY: begin
                sel_o = oy_r;
                sel_d = dy_r;
            end
            MZ: begin
                sel_o = oz_r;
                sel_d = dz_r;
            end
            default: begin
                sel_o = ox_r;
                sel_d = dx_r;
            end
        endcase
    end

    assign d_ext  = {{32{sel_d[31]}}, sel_d};
    assign t_ext  = {{32{t_r[31]}}, t_r};
    assign o_ext  = {{32{sel_o[31]}}, sel_o};
    assign prod   = d_ext * t_ext;
    assign scaled = prod >>> FRAC;
    assign sum    = o_ext + scaled;

    // The sum fits in 32 bits only when bits 63..31 are all copies of the sign bit.
    assign c_ovf = ~((&sum[63:31]) | ~(|sum[63:31]));

    always_comb begin
        c_res = sum[31:0];
        if (SATURATE && c_ovf) begin
            c_res = sum[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ox_r      <= '0;
            oy_r      <= '0;
            oz_r      <= '0;
            dx_r      <= '0;
            dy_r      <= '0;
            dz_r      <= '0;
            t_r       <= '0;
            px        <= '0;
            py        <= '0;
            pz        <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ox_r  <= ox;
                        oy_r  <= oy;
                        oz_r  <= oz;
                        dx_r  <= dx;
                        dy_r  <= dy;
                        dz_r  <= dz;
                        t_r   <= t;
                        ovf   <= 1'b0;
                        state <= MX;
                    end
                end
                MX: begin
                    px    <= c_res;
                    ovf   <= ovf | c_ovf;
                    state <= MY;
                end
                MY: begin
                    py    <= c_res;
                    ovf   <= ovf | c_ovf;
                    state <= MZ;
                end
                MZ: begin
                    pz        <= c_res;
                    ovf       <= ovf | c_ovf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ray_point_v.md
Name: ray_point_v

Overview:
- Reconstructs the point along a ray at parameter t: P = O + t·D, per component, in signed 16.16 fixed point.
- It is the inverse of the vector-subtract stage that turns hit points into origin-relative vectors. It feeds hit points back into the shading and intersection pipeline.
- Uses one shared signed 32x32 multiplier, sequenced over x, y and z by a small FSM.
- Uses a valid/ready handshake on both input and output.

Parameters:
- FRAC, 16, number of fractional bits; the product is arithmetic-shifted right by FRAC.
- SATURATE, 1, 1 = clamp to the signed 32-bit range on overflow; 0 = wrap (keep the low 32 bits).

Ports:
- clk  input  1  system clock, all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- ox, oy, oz  input  32  ray origin, signed 16.16.
- dx, dy, dz  input  32  ray direction, signed 16.16.
- t  input  32  ray parameter, signed 16.16.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- px, py, pz  output  32  point components, signed 16.16, registered.
- ovf  output  1  at least one component overflowed in the current result.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE.
  - px, py, pz = 0; out_valid = 0; ovf = 0; internal operand registers = 0.
  - in_ready = 1 once rst_n is high (in_ready is a decode of IDLE).
- FSM states: IDLE, MX, MY, MZ, DONE.
  - IDLE: in_ready = 1. On a rising edge with in_valid = 1, capture all seven operands, clear ovf, go to MX. Otherwise stay.
  - MX: compute x; register px; go to MY.
  - MY: compute y; register py; go to MZ.
  - MZ: compute z; register pz; set out_valid = 1; go to DONE.
  - DONE: out_valid = 1. px, py, pz and ovf are held stable. When out_ready = 1 at a rising edge, clear out_valid and go to IDLE. Otherwise stay.
- in_ready = 0 in every state except IDLE. Input accepted at edge E0 → out_valid high after edge E3 (3-cycle latency).
- Throughput: one transaction per 5 cycles minimum, since a new accept can only occur in IDLE, one cycle after the output handshake.
- Operands are captured at accept. Changes on the input ports after accept do not affect the result.
- in_valid may be held high while busy. It is only sampled in IDLE.
- Arithmetic, per component c:
  - prod = signed(dc) × signed(t), 64-bit exact.
  - scaled = prod >>> FRAC (arithmetic shift, i.e. floor toward −inf, no rounding).
  - sum = sext64(oc) + scaled.
  - Overflow when sum > 2^31−1 or sum < −2^31.
  - If overflow and SATURATE = 1: result = 0x7FFFFFFF (positive) or 0x80000000 (negative).
  - If overflow and SATURATE = 0: result = sum[31:0].
  - ovf is the OR of the three component overflow flags. It is sticky within a transaction and cleared on the next accept.
- Outputs keep their last values in IDLE. Consumers must qualify them with out_valid.
- Reset asserted mid-transaction (any state): the transaction is discarded, all outputs go to 0 immediately, and no out_valid pulse occurs.
- out_ready while out_valid = 0 is ignored.

Test Plan:
- Basic: o = (0x00010000, 0x00020000, 0x00030000), d = (0x00008000, 0xFFFF0000, 0x00000000), t = 0x00020000 → out_valid 3 cycles after accept; px = 0x00020000, py = 0x00000000, pz = 0x00030000, ovf = 0.
- Floor on negative: o = 0, dx = 0xFFFFFFFF, t = 0x00008000 → px = 0xFFFFFFFF. With dx = 0x00000001 → px = 0x00000000.
- Overflow: ox = 0x7FFF0000, dx = 0x00010000, t = 0x00020000, SATURATE = 1 → px = 0x7FFFFFFF, ovf = 1. Same stimulus with SATURATE = 0 → px = 0x80010000, ovf = 1. Next transaction with no overflow → ovf = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid rises → px, py, pz and ovf stable, in_ready = 0, in_valid pulses ignored. Raise out_ready → out_valid falls next edge, in_ready = 1 the same cycle.
- Back-to-back: in_valid held high with two operand sets → second accept occurs exactly one cycle after the first output handshake; results match the reference model for each set.
- Reset mid-op: assert rst_n low while the FSM is in MY → px = py = pz = 0, out_valid = 0 asynchronously. After release, in_ready = 1 and a fresh transaction completes correctly.
